fir_sse_stream: RTL

// Parametrised streaming FIR filter with an in-line sum-of-squared-error (SSE) checker.

---
 rtl/fir_sse_stream_if.sv | 42 ++++
 rtl/fir_sse_stream.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fir_sse_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_sse_stream_if
// Brief    : Sample/golden handshake, coefficient port and SSE result bundle.
// Revision : 1.0
// ============================================================================
interface fir_sse_stream_if #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int SSE_W  = 64,
    parameter int CNT_W  = 32
);
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OUT_W = DATA_W + COEF_W + $clog2(TAPS);

    logic                     start;
    logic                     stop;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in;
    logic signed [OUT_W-1:0]  out_gold;
    logic                     next;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_filt;
    logic [SSE_W-1:0]         out_sse;
    logic [CNT_W-1:0]         count;
    logic                     ready;

    modport master (
        output start, stop, coef_we, coef_addr, coef_data, in_valid, in, out_gold,
        input  next, out_valid, out_filt, out_sse, count, ready
    );

    modport slave (
        input  start, stop, coef_we, coef_addr, coef_data, in_valid, in, out_gold,
        output next, out_valid, out_filt, out_sse, count, ready
    );
endinterface
`default_nettype wire

// File: rtl/fir_sse_stream.sv
`default_nettype none
// ============================================================================
// Module   : fir_sse_stream
// Brief    : Streaming FIR with run-time coefficients and saturating SSE check.
// Revision : 1.0
// ============================================================================
module fir_sse_stream #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int SSE_W  = 64,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    fir_sse_stream_if.slave     bus
);
    localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OUT_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SQ_W   = 2 * OUT_W + 2;
    localparam int ACC_W  = ((SSE_W > SQ_W) ? SSE_W : SQ_W) + 1;
    localparam logic [AW:0] TAPS_L = (AW + 1)'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic signed [COEF_W-1:0] r_coef    [TAPS];
    logic signed [DATA_W-1:0] r_dly     [TAPS];
    logic signed [DATA_W-1:0] w_dly_nxt [TAPS];
    logic signed [PROD_W-1:0] r_prod    [TAPS];

    logic                     r_v1;
    logic signed [OUT_W-1:0]  r_gold1;
    logic signed [OUT_W-1:0]  r_gold2;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_filt;
    logic [SSE_W-1:0]         r_out_sse;
    logic [CNT_W-1:0]         r_count;

    logic                     w_idle_like;
    logic                     w_accept;
    logic                     w_clear;
    logic                     w_coef_ok;
    logic signed [OUT_W-1:0]  w_sum;
    logic signed [SQ_W-1:0]   w_err;
    logic [SQ_W-1:0]          w_sq;
    logic [ACC_W-1:0]         w_acc;
    logic [SSE_W-1:0]         w_sse_nxt;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = bus.in_valid && (r_state == S_RUN);
    assign w_clear     = bus.start && w_idle_like;
    assign w_coef_ok   = bus.coef_we && w_idle_like && ({1'b0, bus.coef_addr} < TAPS_L);

    assign bus.next      = (r_state == S_RUN);
    assign bus.ready     = (r_state == S_DONE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_filt  = r_out_filt;
    assign bus.out_sse   = r_out_sse;
    assign bus.count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // DRAIN only needs stages 1 and 2 empty: stage 3 commits on the same edge as the exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (bus.stop)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_v1 && !r_out_valid) w_state_nxt = S_DONE;
            S_DONE:  if (bus.start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dly_nxt[0] = bus.in;
        for (int k = 1; k < TAPS; k++) w_dly_nxt[k] = r_dly[k-1];
    end

    // Stage 1: delay line and per-tap products, fed from the post-shift taps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
                r_dly[k]  <= '0;
                r_prod[k] <= '0;
            end
            r_v1    <= 1'b0;
            r_gold1 <= '0;
        end else begin
            if (w_coef_ok) r_coef[bus.coef_addr] <= bus.coef_data;
            if (w_clear) begin
                for (int k = 0; k < TAPS; k++) r_dly[k] <= '0;
            end else if (w_accept) begin
                for (int k = 0; k < TAPS; k++) r_dly[k] <= w_dly_nxt[k];
            end
            if (w_accept) begin
                for (int k = 0; k < TAPS; k++)
                    r_prod[k] <= PROD_W'(r_coef[k]) * PROD_W'(w_dly_nxt[k]);
                r_gold1 <= bus.out_gold;
            end
            r_v1 <= w_accept;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) w_sum = w_sum + OUT_W'(r_prod[k]);
    end

    // Stage 2: adder tree result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_filt  <= '0;
            r_gold2     <= '0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_filt <= w_sum;
                r_gold2    <= r_gold1;
            end
        end
    end

    // Error is formed at the square's width so the difference cannot wrap.
    always_comb begin
        w_err     = SQ_W'(r_out_filt) - SQ_W'(r_gold2);
        w_sq      = w_err * w_err;
        w_acc     = ACC_W'(r_out_sse) + ACC_W'(w_sq);
        w_sse_nxt = (|w_acc[ACC_W-1:SSE_W]) ? '1 : w_acc[SSE_W-1:0];
    end

    // Stage 3: saturating SSE and sample count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_sse <= '0;
            r_count   <= '0;
        end else if (w_clear) begin
            r_out_sse <= '0;
            r_count   <= '0;
        end else if (r_out_valid) begin
            r_out_sse <= w_sse_nxt;
            r_count   <= r_count + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire
